// File: rtl/mdu_unit.sv
// mdu_unit: E-stage multiply/divide unit with architectural HI/LO registers.
// Launches mult/multu/div/divu into a fixed-latency busy window, then commits
// the pending result to HI/LO. Also serves mfhi/mflo/mthi/mtlo.
// Optional feature macro: MDU_MADD_EN adds madd/maddu/msub/msubu
// (ops 9-12). These accumulate into HI/LO and use the multiply latency.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [3:0]  MDU_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDU_RD
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pHi_q, pHi_d;
    logic [31:0]      pLo_q, pLo_d;
    logic             pWrite_q, pWrite_d;

    logic             isDiv;
    logic             isLaunch;
    logic             mtWrite;

    logic [63:0]      prodS;
    logic [63:0]      prodU;
    logic [31:0]      divisor;
    logic [31:0]      quotS;
    logic [31:0]      remS;
    logic [31:0]      quotU;
    logic [31:0]      remU;

    logic [31:0]      resHi;
    logic [31:0]      resLo;
    logic             resValid;

    // Decode the E-stage op into launch / move-to classes; any launch or
    // HI/LO write is suppressed by an exception request or an op in flight.
    always_comb begin
        isDiv    = (MDU_op == OP_DIV) || (MDU_op == OP_DIVU);
        isLaunch = (MDU_op == OP_MULT) || (MDU_op == OP_MULTU) || isDiv;
`ifdef MDU_MADD_EN
        if ((MDU_op == OP_MADD) || (MDU_op == OP_MADDU) ||
            (MDU_op == OP_MSUB) || (MDU_op == OP_MSUBU)) begin
            isLaunch = 1'b1;
        end
`endif
        start   = isLaunch && !Req && (state_q == S_IDLE);
        mtWrite = !Req && (state_q == S_IDLE) &&
                  ((MDU_op == OP_MTHI) || (MDU_op == OP_MTLO));
    end

    // Raw arithmetic datapath. Division uses 33-bit signed operands so that
    // 0x80000000 / -1 wraps cleanly instead of overflowing, and a zero
    // divisor is replaced by 1 so the divider never sees it (that result is
    // discarded anyway).
    always_comb begin
        prodS   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prodU   = {32'b0, A} * {32'b0, B};
        divisor = (B == 32'd0) ? 32'd1 : B;
        quotS   = 32'($signed({A[31], A}) / $signed({divisor[31], divisor}));
        remS    = 32'($signed({A[31], A}) % $signed({divisor[31], divisor}));
        quotU   = A / divisor;
        remU    = A % divisor;
    end

    // Select the result that will sit in the pending registers until the
    // busy window ends; a divide by zero marks the result as not to commit.
    always_comb begin
        resHi    = 32'd0;
        resLo    = 32'd0;
        resValid = 1'b1;
        case (MDU_op)
            OP_MULT:  {resHi, resLo} = prodS;
            OP_MULTU: {resHi, resLo} = prodU;
            OP_DIV: begin
                resHi    = remS;
                resLo    = quotS;
                resValid = (B != 32'd0);
            end
            OP_DIVU: begin
                resHi    = remU;
                resLo    = quotU;
                resValid = (B != 32'd0);
            end
`ifdef MDU_MADD_EN
            OP_MADD:  {resHi, resLo} = {hi_q, lo_q} + prodS;
            OP_MADDU: {resHi, resLo} = {hi_q, lo_q} + prodU;
            OP_MSUB:  {resHi, resLo} = {hi_q, lo_q} - prodS;
            OP_MSUBU: {resHi, resLo} = {hi_q, lo_q} - prodU;
`endif
            default: begin
                resHi    = 32'd0;
                resLo    = 32'd0;
                resValid = 1'b1;
            end
        endcase
    end

    // Next-state logic: launch from IDLE, count down in BUSY, commit the
    // pending result on the last busy cycle; moves to HI/LO only in IDLE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        pHi_d    = pHi_q;
        pLo_d    = pLo_q;
        pWrite_d = pWrite_q;
        if (state_q == S_IDLE) begin
            if (start) begin
                pHi_d    = resHi;
                pLo_d    = resLo;
                pWrite_d = resValid;
                cnt_d    = isDiv ? DIV_LOAD : MULT_LOAD;
                state_d  = S_BUSY;
            end else if (mtWrite) begin
                if (MDU_op == OP_MTHI) begin
                    hi_d = A;
                end else begin
                    lo_d = A;
                end
            end
        end else begin
            if (cnt_q == '0) begin
                state_d = S_IDLE;
                if (pWrite_q) begin
                    hi_d = pHi_q;
                    lo_d = pLo_q;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // State, counter, pending and architectural registers; reset aborts any
    // operation in flight and clears HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            pHi_q    <= 32'd0;
            pLo_q    <= 32'd0;
            pWrite_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            pHi_q    <= pHi_d;
            pLo_q    <= pLo_d;
            pWrite_q <= pWrite_d;
        end
    end

    // Read port shows the committed registers only, never pending results.
    always_comb begin
        busy = (state_q == S_BUSY);
        HI   = hi_q;
        LO   = lo_q;
        if (MDU_op == OP_MFHI) begin
            MDU_RD = hi_q;
        end else if (MDU_op == OP_MFLO) begin
            MDU_RD = lo_q;
        end else begin
            MDU_RD = 32'd0;
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed, table-driven checks for mdu_unit plus hand-written
// sequences for exception requests and reset during an operation.
module tb_mdu_unit;

    logic        clk;
    logic        reset;
    logic        Req;
    logic [3:0]  MDU_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDU_RD;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        req;
        int          n;
        logic        expStart;
        logic [31:0] expRd;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vec_t;

    vec_t vecs[$];

    mdu_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Req   (Req),
        .MDU_op(MDU_op),
        .A     (A),
        .B     (B),
        .start (start),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO),
        .MDU_RD(MDU_RD)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic req, input int n, input logic expStart,
                                input logic [31:0] expRd, input logic [31:0] expHi,
                                input logic [31:0] expLo);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.req = req; v.n = n;
        v.expStart = expStart; v.expRd = expRd; v.expHi = expHi; v.expLo = expLo;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Present one op for one cycle, re-present it during the busy window
    // (must be ignored), then check the committed HI/LO.
    task automatic applyStimulus(input vec_t v, input string tag);
        MDU_op = v.op; A = v.a; B = v.b; Req = v.req;
        @(negedge clk);
        checkOutput({tag, " start"}, 32'(start), 32'(v.expStart));
        checkOutput({tag, " rd"}, MDU_RD, v.expRd);
        nextCycle();
        Req = 1'b0;
        for (int i = 0; i < v.n; i++) begin
            @(negedge clk);
            checkOutput($sformatf("%s busy%0d", tag, i + 1), 32'(busy), 32'd1);
            checkOutput($sformatf("%s nostart%0d", tag, i + 1), 32'(start), 32'd0);
            nextCycle();
        end
        MDU_op = 4'd0;
        @(negedge clk);
        checkOutput({tag, " idle"}, 32'(busy), 32'd0);
        checkOutput({tag, " HI"}, HI, v.expHi);
        checkOutput({tag, " LO"}, LO, v.expLo);
        nextCycle();
    endtask

    initial begin
        vecs.push_back(mk(4'd1, 32'hFFFFFFFE, 32'd3,        1'b0, 5,  1'b1, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFA));
        vecs.push_back(mk(4'd2, 32'hFFFFFFFE, 32'd3,        1'b0, 5,  1'b1, 32'd0,        32'h00000002, 32'hFFFFFFFA));
        vecs.push_back(mk(4'd3, 32'hFFFFFFF9, 32'd2,        1'b0, 10, 1'b1, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD));
        vecs.push_back(mk(4'd4, 32'd7,        32'd0,        1'b0, 10, 1'b1, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD));
        vecs.push_back(mk(4'd7, 32'h12345678, 32'd0,        1'b0, 0,  1'b0, 32'd0,        32'h12345678, 32'hFFFFFFFD));
        vecs.push_back(mk(4'd5, 32'd0,        32'd0,        1'b0, 0,  1'b0, 32'h12345678, 32'h12345678, 32'hFFFFFFFD));
        vecs.push_back(mk(4'd8, 32'hAAAA5555, 32'd0,        1'b1, 0,  1'b0, 32'd0,        32'h12345678, 32'hFFFFFFFD));
        vecs.push_back(mk(4'd6, 32'd0,        32'd0,        1'b0, 0,  1'b0, 32'hFFFFFFFD, 32'h12345678, 32'hFFFFFFFD));
        vecs.push_back(mk(4'd1, 32'd5,        32'd5,        1'b1, 0,  1'b0, 32'd0,        32'h12345678, 32'hFFFFFFFD));
        vecs.push_back(mk(4'd4, 32'd100,      32'd7,        1'b0, 10, 1'b1, 32'd0,        32'h00000002, 32'h0000000E));
        vecs.push_back(mk(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 10, 1'b1, 32'd0,        32'h00000000, 32'h80000000));
        vecs.push_back(mk(4'd3, 32'd7,        32'hFFFFFFFE, 1'b0, 10, 1'b1, 32'd0,        32'h00000001, 32'hFFFFFFFD));
        vecs.push_back(mk(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5,  1'b1, 32'd0,        32'hFFFFFFFE, 32'h00000001));
        vecs.push_back(mk(4'd1, 32'h80000000, 32'h80000000, 1'b0, 5,  1'b1, 32'd0,        32'h40000000, 32'h00000000));
        vecs.push_back(mk(4'd1, 32'hFFFFFFFF, 32'd7,        1'b0, 5,  1'b1, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9));
        vecs.push_back(mk(4'd8, 32'hCAFEF00D, 32'd0,        1'b0, 0,  1'b0, 32'd0,        32'hFFFFFFFF, 32'hCAFEF00D));
`ifndef MDU_MADD_EN
        vecs.push_back(mk(4'd9, 32'd2,        32'd3,        1'b0, 0,  1'b0, 32'd0,        32'hFFFFFFFF, 32'hCAFEF00D));
`endif
        vecs.push_back(mk(4'd15, 32'd1,       32'd1,        1'b0, 0,  1'b0, 32'd0,        32'hFFFFFFFF, 32'hCAFEF00D));
        vecs.push_back(mk(4'd6, 32'd0,        32'd0,        1'b0, 0,  1'b0, 32'hCAFEF00D, 32'hFFFFFFFF, 32'hCAFEF00D));

        reset = 1'b1; Req = 1'b0; MDU_op = 4'd0; A = 32'd0; B = 32'd0;
        nextCycle();
        nextCycle();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset start", 32'(start), 32'd0);
        checkOutput("reset HI", HI, 32'd0);
        checkOutput("reset LO", LO, 32'd0);
        checkOutput("reset rd", MDU_RD, 32'd0);
        nextCycle();

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], $sformatf("v%0d", i));
        end

        // Req during a div in flight has no effect; ops while busy ignored.
        MDU_op = 4'd3; A = 32'd100; B = 32'd7; Req = 1'b0;
        @(negedge clk);
        checkOutput("reqdiv start", 32'(start), 32'd1);
        nextCycle();
        for (int c = 1; c <= 10; c++) begin
            Req = (c == 3);
            if (c == 3) begin
                MDU_op = 4'd1; A = 32'd9; B = 32'd9;
            end else if (c == 5) begin
                MDU_op = 4'd7; A = 32'hDEAD0000;
            end else begin
                MDU_op = 4'd0;
            end
            @(negedge clk);
            checkOutput($sformatf("reqdiv busy%0d", c), 32'(busy), 32'd1);
            nextCycle();
        end
        Req = 1'b0; MDU_op = 4'd0;
        @(negedge clk);
        checkOutput("reqdiv idle", 32'(busy), 32'd0);
        checkOutput("reqdiv HI", HI, 32'd2);
        checkOutput("reqdiv LO", LO, 32'd14);
        nextCycle();

        // Reset during busy cycle 3 of mult 5x5 aborts without a later commit.
        MDU_op = 4'd1; A = 32'd5; B = 32'd5;
        @(negedge clk);
        checkOutput("rstmul start", 32'(start), 32'd1);
        nextCycle();
        MDU_op = 4'd0;
        nextCycle();
        nextCycle();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rstmul busy3", 32'(busy), 32'd1);
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rstmul busy", 32'(busy), 32'd0);
        checkOutput("rstmul HI", HI, 32'd0);
        checkOutput("rstmul LO", LO, 32'd0);
        for (int c = 0; c < 8; c++) nextCycle();
        @(negedge clk);
        checkOutput("rstmul late busy", 32'(busy), 32'd0);
        checkOutput("rstmul late HI", HI, 32'd0);
        checkOutput("rstmul late LO", LO, 32'd0);
        nextCycle();

`ifdef MDU_MADD_EN
        applyStimulus(mk(4'd7,  32'd0,  32'd0, 1'b0, 0, 1'b0, 32'd0, 32'd0, 32'd0), "m0");
        applyStimulus(mk(4'd8,  32'd10, 32'd0, 1'b0, 0, 1'b0, 32'd0, 32'd0, 32'd10), "m1");
        applyStimulus(mk(4'd9,  32'd2,  32'd3, 1'b0, 5, 1'b1, 32'd0, 32'd0, 32'd16), "m2");
        applyStimulus(mk(4'd12, 32'd4,  32'd5, 1'b0, 5, 1'b1, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFC), "m3");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
# mdu_unit

E-stage multiply/divide unit of the pipelined MIPS CPU. It executes mult/multu/div/divu and owns the HI/LO registers. It serves mfhi/mflo/mthi/mtlo, and produces the `start` and `busy` signals that the stall controller uses to hold MDU instructions in D while an operation is in flight. It models a multi-cycle iterative unit: results commit to HI/LO only after a fixed latency.

## Interface
- `MULT_CYCLES`, 5, busy cycles for mult/multu (and madd family when enabled); must be ≥1
- `DIV_CYCLES`, 10, busy cycles for div/divu; must be ≥1
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high; one clock and reset only
- `Req`  in  1  interrupt/exception request this cycle; suppresses any new start or HI/LO write from the E-stage instruction
- `MDU_op`  in  4  E-stage op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu, 11 msub, 12 msubu, others none
- `A`  in  32  forwarded rs value (E stage)
- `B`  in  32  forwarded rt value (E stage)
- `start`  out  1  combinational: E-stage op is a launching op, `Req`=0 and state IDLE
- `busy`  out  1  registered: operation in flight
- `HI`  out  32  architectural HI
- `LO`  out  32  architectural LO
- `MDU_RD`  out  32  combinational read data: HI for mfhi, LO for mflo, else 0

## Operation
- States: IDLE, BUSY. Down-counter `cnt` sized for max(MULT_CYCLES, DIV_CYCLES).
- IDLE and `start`=1: compute the result into pending registers `pHI`/`pLO`, load `cnt` with N−1 (N = MULT_CYCLES or DIV_CYCLES), go to BUSY.
- BUSY: decrement `cnt` each cycle. When `cnt`=0, write `pHI`/`pLO` to HI/LO and return to IDLE.
- mult: {HI,LO} = signed 64-bit A×B. multu: unsigned product.
- div: LO = A/B, HI = A%B, signed. Quotient truncates toward zero; the remainder takes the sign of the dividend.
- divu: unsigned quotient and remainder.
- Divide by zero (B=0): state timing is unchanged (busy for DIV_CYCLES), and HI/LO are left unmodified at commit.
- mthi/mtlo with `Req`=0: HI←A or LO←A at the end of the cycle. Valid only in IDLE.
- `Req` has no effect on an operation already in BUSY. That instruction has retired past E, so it completes and commits.
- Op codes issued while BUSY are ignored. The stall controller prevents this; the RTL must still not corrupt state.
- `MDU_RD` reads the current HI/LO registers directly. It does not bypass pending results.

## Timing
- Reset: state IDLE, `cnt`=0, `busy`=0, HI=0, LO=0, `pHI`=`pLO`=0. `start`=0 and `MDU_RD`=0 follow combinationally from the reset state and a none op.
- Reset asserted mid-operation aborts it. The pending result is discarded, and HI/LO are 0 on the next cycle.
- Launching op in E during cycle T with `Req`=0:
  - `start`=1 in T;
  - `busy`=1 in cycles T+1…T+N;
  - HI/LO updated at the edge ending T+N and visible in T+N+1;
  - `busy`=0 in T+N+1.
- mfhi/mflo behind a launch stall in D through T+N. They enter E in T+N+1 and read the new value.
- mthi/mtlo: single cycle, visible the next cycle.
- `Req`=1 in T with a launching op: `start`=0, no state change, HI/LO unchanged.

## Configuration
- `MDU_MADD_EN` defined:
  - ops 9–12 are launching ops with MULT_CYCLES latency;
  - madd: {HI,LO} += signed A×B; maddu: unsigned;
  - msub: {HI,LO} −= signed A×B; msubu: unsigned;
  - the accumulation is 64-bit modulo and uses HI/LO as sampled at launch.
- Not defined: ops 9–12 behave as none. `start`=0 and there is no state change.

## Test plan
- Reset then mult A=0xFFFFFFFE (−2), B=3 → `start`=1 for 1 cycle, `busy` 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (−7), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/0 → HI/LO unchanged, `busy` still 10 cycles.
- mthi A=0x12345678, then mfhi → `MDU_RD`=0x12345678 next cycle; mtlo with `Req`=1 → LO unchanged.
- mult with `Req`=1 in launch cycle → `start`=0, `busy` stays 0, HI/LO unchanged; `Req`=1 during cycle 3 of a div → div still commits on schedule.
- `reset` asserted at busy cycle 3 of mult 5×5 → next cycle `busy`=0, HI=LO=0, no later commit.
- With `MDU_MADD_EN`: HI=0, LO=10, madd A=2, B=3 → LO=16; msubu A=4, B=5 → {HI,LO}=0xFFFFFFFF_FFFFFFFC.
